// File: rtl/sdio_pkg.sv
// Shared types and constants for the SDIO receive path.
package sdio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    END
  } sdio_rx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  localparam int STAT_TIMEOUT = 0;
  localparam int STAT_CRC     = 1;
  localparam int STAT_OVF     = 2;

endpackage

// File: rtl/sdio_crc16.sv
// Serial CRC16 for a single DAT lane. Once the received CRC bits are fed back in,
// the register drains to zero when every bit matches.
module sdio_crc16
  import sdio_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      crc_o <= '0;
    end else if (en_i) begin
      crc_o <= {crc_o[14:0], 1'b0} ^ (CRC16_POLY & {16{crc_o[15] ^ bit_i}});
    end
  end

endmodule

// File: rtl/sdio_data_rx.sv
// SDIO read-data deserializer: start bit, payload, per-lane CRC16, end bit per block;
// packs payload bytes into 32-bit words on a valid/ready stream.
//
// state      | meaning
// IDLE       | no transfer armed
// WAIT_START | waiting for a start bit, timeout counting down
// DATA       | shifting payload bits/nibbles into bytes
// CRC        | 16 CRC bits compared against the per-lane registers
// END        | end bit check, then next block or finish
module sdio_data_rx
  import sdio_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        clr_i,
  input  logic        quad_i,
  input  logic [9:0]  block_size_i,
  input  logic [7:0]  block_num_i,
  input  logic [3:0]  sddata_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        eot_o,
  output logic [2:0]  status_o
);

  sdio_rx_state_e state, state_d;

  logic            quad;
  logic [9:0]      block_size;
  logic [7:0]      block_num;
  logic [9:0]      byte_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      blk_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      crc_cnt;
  logic [6:0]      shift;
  logic [31:0]     word_buf;
  logic [15:0]     crc [4];

  logic [3:0]  lane_en, crc_msb;
  logic [7:0]  byte_val;
  logic [31:0] word_val;
  logic        start_bit, byte_done, last_byte, word_done;
  logic        crc_bad, end_bad, resid_bad, timeout_hit, last_block;
  logic        crc_clr, crc_en, eot_d;

  assign lane_en     = quad ? 4'hF : 4'h1;
  assign start_bit   = (sddata_i & lane_en) == 4'h0;
  assign byte_done   = (state == DATA) && (quad ? bit_cnt[0] : (bit_cnt == 3'd7));
  assign byte_val    = quad ? {shift[3:0], sddata_i} : {shift[6:0], sddata_i[0]};
  assign last_byte   = byte_cnt == block_size;
  assign word_done   = byte_done && ((byte_cnt[1:0] == 2'd3) || last_byte);
  assign timeout_hit = to_cnt == '0;
  assign last_block  = blk_cnt == block_num;
  assign busy_o      = state != IDLE;

  always_comb begin
    crc_msb   = 4'h0;
    resid_bad = 1'b0;
    for (int l = 0; l < 4; l++) begin
      crc_msb[l] = crc[l][15];
      if (lane_en[l] && (crc[l] != 16'h0)) resid_bad = 1'b1;
    end
  end

  assign crc_bad = (state == CRC) && (((sddata_i ^ crc_msb) & lane_en) != 4'h0);
  // A matching CRC leaves every active register at zero, so a residue is a mismatch too.
  assign end_bad = (state == END) && (((sddata_i & lane_en) != lane_en) || resid_bad);

  always_comb begin
    word_val = word_buf;
    word_val[{byte_cnt[1:0], 3'b000} +: 8] = byte_val;
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    sdio_crc16 u_crc (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .clr_i  (crc_clr),
      .en_i   (crc_en & lane_en[l]),
      .bit_i  (sddata_i[l]),
      .crc_o  (crc[l])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    eot_d   = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    case (state)
      IDLE: if (start_i) state_d = WAIT_START;
      WAIT_START: begin
        if (start_bit) begin
          state_d = DATA;
          crc_clr = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
          eot_d   = 1'b1;
        end
      end
      DATA: begin
        crc_en = 1'b1;
        if (byte_done && last_byte) state_d = CRC;
      end
      CRC: begin
        crc_en = 1'b1;
        if (crc_cnt == 4'd15) state_d = END;
      end
      END: begin
        if (status_o[STAT_CRC] || end_bad || last_block) begin
          state_d = IDLE;
          eot_d   = 1'b1;
        end else begin
          state_d = WAIT_START;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) begin
      state_d = IDLE;
      eot_d   = 1'b0;
      crc_clr = 1'b1;
      crc_en  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      quad       <= 1'b0;
      block_size <= '0;
      block_num  <= '0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      blk_cnt    <= '0;
      to_cnt     <= '0;
      crc_cnt    <= '0;
      shift      <= '0;
      word_buf   <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      eot_o      <= 1'b0;
      status_o   <= '0;
    end else begin
      eot_o <= eot_d;
      if (valid_o && ready_i) valid_o <= 1'b0;
      if (clr_i) begin
        status_o <= '0;
        valid_o  <= 1'b0;
        word_buf <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              quad       <= quad_i;
              block_size <= block_size_i;
              block_num  <= block_num_i;
              status_o   <= '0;
              blk_cnt    <= '0;
              to_cnt     <= TO_W'(TIMEOUT_CYCLES - 1);
            end
          end
          WAIT_START: begin
            to_cnt <= to_cnt - 1'b1;
            if (start_bit) begin
              to_cnt   <= TO_W'(TIMEOUT_CYCLES - 1);
              byte_cnt <= '0;
              bit_cnt  <= '0;
              word_buf <= '0;
            end else if (timeout_hit) begin
              status_o[STAT_TIMEOUT] <= 1'b1;
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= byte_val[6:0];
            if (byte_done) begin
              bit_cnt  <= '0;
              byte_cnt <= byte_cnt + 1'b1;
              word_buf <= word_val;
            end
            if (word_done) begin
              word_buf <= '0;
              data_o   <= word_val;
              valid_o  <= 1'b1;
              // The card cannot be stalled: an unaccepted word is simply lost.
              if (valid_o && !ready_i) status_o[STAT_OVF] <= 1'b1;
            end
            if (byte_done && last_byte) crc_cnt <= '0;
          end
          CRC: begin
            crc_cnt <= crc_cnt + 1'b1;
            if (crc_bad) status_o[STAT_CRC] <= 1'b1;
          end
          END: begin
            if (end_bad) status_o[STAT_CRC] <= 1'b1;
            if (state_d == WAIT_START) begin
              blk_cnt <= blk_cnt + 1'b1;
              to_cnt  <= TO_W'(TIMEOUT_CYCLES - 1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
